// File: rtl/ps2_host.sv
// ps2_host: PS/2 host port on the 6502 bus, RX FIFO with E0/F0 folding.
// Define PS2_TX_EN to build the host-to-device command transmitter.

module ps2_host #(
  parameter logic [15:0] BASE_ADR   = 16'h4000,
  parameter logic [15:0] ADR_MASK   = 16'hE000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TIMEOUT    = 2000,
  parameter int          INHIBIT    = 1500
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe,
  input  logic [15:0] sys_adr,
  input  logic        sys_rd,
  input  logic        sys_wr,
  input  logic [7:0]  sys_data_in,
  output logic [7:0]  sys_data_out,
  output logic        sys_data_oe,
  output logic        sys_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + INHIBIT + 2);

  localparam logic [0:0] RX_IDLE = 1'b0;
  localparam logic [0:0] RX_BITS = 1'b1;

  // pin synchronisers and falling-edge detect
  logic c_s1_q, c_s2_q, c_prev_q;
  logic d_s1_q, d_s2_q;
  logic fall;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      c_s1_q   <= 1'b1;
      c_s2_q   <= 1'b1;
      c_prev_q <= 1'b1;
      d_s1_q   <= 1'b1;
      d_s2_q   <= 1'b1;
    end else begin
      c_s1_q   <= ps2_clk_in;
      c_s2_q   <= c_s1_q;
      c_prev_q <= c_s2_q;
      d_s1_q   <= ps2_data_in;
      d_s2_q   <= d_s1_q;
    end
  end

  assign fall = c_prev_q & ~c_s2_q;

  // bus decode
  logic sel, rd_en, wr_en;
  logic ctrl_wr, flush, clr;

  assign sel     = (sys_adr & ADR_MASK) == BASE_ADR;
  assign rd_en   = sys_rd & sel;
  assign wr_en   = sys_wr & sel;
  assign ctrl_wr = wr_en & (sys_adr[1:0] == 2'd2);
  assign flush   = ctrl_wr & sys_data_in[1];
  assign clr     = ctrl_wr & sys_data_in[2];

  // TX-side handshake signals
  logic tx_busy, tx_inh, tx_chg, tx_nack_evt;

  // shared no-edge timer
  logic [TW-1:0] tmr_q, tmr_d;
  logic          tmr_clr, tmo;

  // RX state
  logic [0:0] rx_state_q, rx_state_d;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic       rx_par_q, rx_par_d;
  logic       pend_e0_q, pend_e0_d;
  logic       pend_f0_q, pend_f0_d;
  logic       push_req, rx_ferr_evt;

  // FIFO
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count;
  logic          empty, full, pop;
  logic          push_ok, ovf_evt;
  logic [9:0]    head, push_entry;

  // sticky status and control
  logic ferr_q, ferr_d;
  logic ovf_q, ovf_d;
  logic tx_nack_q, tx_nack_d;
  logic irq_en_q, irq_en_d;

  // read path
  logic [7:0] status, rdata;
  logic [7:0] dout_q;
  logic       doe_q;

  assign tmr_clr = (fall & ~tx_inh)
                 | ((rx_state_q == RX_IDLE) & ~tx_busy)
                 | tx_chg;
  assign tmo     = tmr_q >= TW'(TIMEOUT - 1);

  always_comb begin
    tmr_d = tmr_q;
    if (tmr_clr) begin
      tmr_d = '0;
    end else if (!(&tmr_q)) begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_sh_d     = rx_sh_q;
    rx_par_d    = rx_par_q;
    pend_e0_d   = pend_e0_q;
    pend_f0_d   = pend_f0_q;
    push_req    = 1'b0;
    rx_ferr_evt = 1'b0;
    if (tx_busy) begin
      rx_state_d = RX_IDLE;
    end else begin
      unique case (rx_state_q)
        RX_IDLE: begin
          if (fall) begin
            if (!d_s2_q) begin
              rx_state_d = RX_BITS;
              rx_cnt_d   = '0;
            end else begin
              rx_ferr_evt = 1'b1;
            end
          end
        end
        RX_BITS: begin
          if (fall) begin
            if (rx_cnt_q < 4'd8) begin
              rx_sh_d  = {d_s2_q, rx_sh_q[7:1]};
              rx_cnt_d = rx_cnt_q + 4'd1;
            end else if (rx_cnt_q == 4'd8) begin
              rx_par_d = d_s2_q;
              rx_cnt_d = rx_cnt_q + 4'd1;
            end else begin
              rx_state_d = RX_IDLE;
              // odd parity: data plus parity carries an odd count of ones
              if (!(^{rx_sh_q, rx_par_q}) || !d_s2_q) begin
                rx_ferr_evt = 1'b1;
              end else if (rx_sh_q == 8'hE0) begin
                pend_e0_d = 1'b1;
              end else if (rx_sh_q == 8'hF0) begin
                pend_f0_d = 1'b1;
              end else begin
                push_req  = 1'b1;
                pend_e0_d = 1'b0;
                pend_f0_d = 1'b0;
              end
            end
          end else if (tmo) begin
            rx_state_d  = RX_IDLE;
            rx_ferr_evt = 1'b1;
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
    if (flush) begin
      pend_e0_d = 1'b0;
      pend_f0_d = 1'b0;
    end
  end

  assign count      = wr_ptr_q - rd_ptr_q;
  assign empty      = wr_ptr_q == rd_ptr_q;
  assign full       = count == PW'(FIFO_DEPTH);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign push_entry = {pend_f0_q, pend_e0_q, rx_sh_q};
  assign pop        = rd_en & (sys_adr[1:0] == 2'd1) & ~empty;
  assign push_ok    = push_req & (~full | pop);
  assign ovf_evt    = push_req & full & ~pop & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
    end
  end

  // a same-cycle error event wins over a CTRL clear
  assign ferr_d    = (ferr_q & ~clr) | rx_ferr_evt;
  assign ovf_d     = (ovf_q & ~clr) | ovf_evt;
  assign tx_nack_d = (tx_nack_q & ~clr) | tx_nack_evt;
  assign irq_en_d  = ctrl_wr ? sys_data_in[0] : irq_en_q;

  assign status = {~empty, ferr_q,
                   ~empty & head[9], ~empty & head[8],
                   ovf_q, tx_busy, tx_nack_q, full};

  always_comb begin
    rdata = 8'h00;
    unique case (sys_adr[1:0])
      2'd0:    rdata = status;
      2'd1:    rdata = empty ? 8'h00 : head[7:0];
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      tmr_q      <= '0;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
      pend_e0_q  <= 1'b0;
      pend_f0_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      tx_nack_q  <= 1'b0;
      irq_en_q   <= 1'b1;
      dout_q     <= 8'h00;
      doe_q      <= 1'b0;
    end else begin
      tmr_q      <= tmr_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
      pend_e0_q  <= pend_e0_d;
      pend_f0_q  <= pend_f0_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
      tx_nack_q  <= tx_nack_d;
      irq_en_q   <= irq_en_d;
      doe_q      <= rd_en;
      if (rd_en) dout_q <= rdata;
    end
  end

  assign sys_data_out = dout_q;
  assign sys_data_oe  = doe_q;
  assign sys_irq      = ~(irq_en_q &
                          (~empty | ferr_q | ovf_q | tx_nack_q));

`ifdef PS2_TX_EN
  localparam logic [2:0] TX_IDLE    = 3'd0;
  localparam logic [2:0] TX_INHIBIT = 3'd1;
  localparam logic [2:0] TX_START   = 3'd2;
  localparam logic [2:0] TX_BITS    = 3'd3;
  localparam logic [2:0] TX_ACK     = 3'd4;
  localparam logic [2:0] TX_DONE    = 3'd5;

  logic [2:0] tx_state_q, tx_state_d;
  logic [8:0] tx_sh_q, tx_sh_d;
  logic [3:0] tx_cnt_q, tx_cnt_d;
  logic       clk_oe_q, clk_oe_d;
  logic       data_oe_q, data_oe_d;
  logic       tx_wr, tx_abort;

  assign tx_wr = wr_en & (sys_adr[1:0] == 2'd3);

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_sh_d     = tx_sh_q;
    tx_cnt_d    = tx_cnt_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    tx_nack_evt = 1'b0;
    tx_abort    = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_wr) begin
          tx_state_d = TX_INHIBIT;
          tx_sh_d    = {~^sys_data_in, sys_data_in};
          tx_cnt_d   = '0;
          clk_oe_d   = 1'b1;
        end
      end
      TX_INHIBIT: begin
        if (tmr_q >= TW'(INHIBIT - 1)) begin
          tx_state_d = TX_START;
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b1;
        end
      end
      TX_START: begin
        if (fall) begin
          data_oe_d  = ~tx_sh_q[0];
          tx_sh_d    = {1'b0, tx_sh_q[8:1]};
          tx_cnt_d   = 4'd1;
          tx_state_d = TX_BITS;
        end else begin
          tx_abort = tmo;
        end
      end
      TX_BITS: begin
        if (fall) begin
          // tenth edge releases data as the stop bit
          if (tx_cnt_q == 4'd9) begin
            data_oe_d  = 1'b0;
            tx_state_d = TX_ACK;
          end else begin
            data_oe_d = ~tx_sh_q[0];
            tx_sh_d   = {1'b0, tx_sh_q[8:1]};
            tx_cnt_d  = tx_cnt_q + 4'd1;
          end
        end else begin
          tx_abort = tmo;
        end
      end
      TX_ACK: begin
        if (fall) begin
          tx_nack_evt = d_s2_q;
          tx_state_d  = TX_DONE;
        end else begin
          tx_abort = tmo;
        end
      end
      TX_DONE: begin
        if (c_s2_q) tx_state_d = TX_IDLE;
        else        tx_abort   = tmo;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_abort) begin
      tx_state_d  = TX_IDLE;
      clk_oe_d    = 1'b0;
      data_oe_d   = 1'b0;
      tx_nack_evt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      tx_state_q <= TX_IDLE;
      tx_sh_q    <= '0;
      tx_cnt_q   <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sh_q    <= tx_sh_d;
      tx_cnt_q   <= tx_cnt_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign tx_busy     = tx_state_q != TX_IDLE;
  assign tx_inh      = tx_state_q == TX_INHIBIT;
  assign tx_chg      = tx_state_d != tx_state_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
`else
  logic unused_wdata;

  assign unused_wdata = ^sys_data_in[7:3];
  assign tx_busy      = 1'b0;
  assign tx_inh       = 1'b0;
  assign tx_chg       = 1'b0;
  assign tx_nack_evt  = 1'b0;
  assign ps2_clk_oe   = 1'b0;
  assign ps2_data_oe  = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host.sv
// tb_ps2_host: vector table, corner sequences and randomized frames
// checked against a queue-based reference model of the port.

module tb_ps2_host;

  localparam int DEPTH = 8;
  localparam int TMO   = 300;
  localparam int INH   = 50;
  localparam int HALF  = 10;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        dev_clk = 1'b1;
  logic        dev_data = 1'b1;
  logic        clk_pin, data_pin;
  logic        ps2_clk_oe, ps2_data_oe;
  logic [15:0] sys_adr = 16'h0000;
  logic        sys_rd = 1'b0;
  logic        sys_wr = 1'b0;
  logic [7:0]  sys_data_in = 8'h00;
  logic [7:0]  sys_data_out;
  logic        sys_data_oe;
  logic        sys_irq;

  always #5 clk = ~clk;

  assign clk_pin  = dev_clk & ~ps2_clk_oe;
  assign data_pin = dev_data & ~ps2_data_oe;

  ps2_host #(
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT(TMO),
    .INHIBIT(INH)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .ps2_clk_in(clk_pin),
    .ps2_data_in(data_pin),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .sys_adr(sys_adr),
    .sys_rd(sys_rd),
    .sys_wr(sys_wr),
    .sys_data_in(sys_data_in),
    .sys_data_out(sys_data_out),
    .sys_data_oe(sys_data_oe),
    .sys_irq(sys_irq)
  );

  int tests = 0;
  int fails = 0;

  // reference model
  logic [9:0] m_q[$];
  bit m_e0, m_f0, m_ferr, m_ovf, m_irq_en;

  typedef struct {
    logic [7:0] code;
    bit         bad;
    logic [7:0] st;
    bit         irq;
    logic [7:0] rd;
    logic [7:0] st2;
  } vec_t;

  vec_t vt[5];

  logic [7:0] d, exp_d;
  logic       rd_oe;
  logic [9:0] txbits;
  int         n, r;
  bit         bad;

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_e0 = 0; m_f0 = 0; m_ferr = 0; m_ovf = 0; m_irq_en = 1;
  endtask

  task automatic m_frame(input logic [7:0] code, input bit b);
    if (b) m_ferr = 1;
    else if (code == 8'hE0) m_e0 = 1;
    else if (code == 8'hF0) m_f0 = 1;
    else begin
      if (m_q.size() == DEPTH) m_ovf = 1;
      else m_q.push_back({m_f0, m_e0, code});
      m_e0 = 0; m_f0 = 0;
    end
  endtask

  function automatic logic [7:0] m_status();
    logic [9:0] h;
    h = (m_q.size() != 0) ? m_q[0] : 10'd0;
    return {m_q.size() != 0, m_ferr, h[9], h[8], m_ovf,
            1'b0, 1'b0, m_q.size() == DEPTH};
  endfunction

  function automatic logic m_irq();
    return ~(m_irq_en & ((m_q.size() != 0) | m_ferr | m_ovf));
  endfunction

  task automatic bus_read(input logic [1:0] a, output logic [7:0] v);
    @(negedge clk);
    sys_adr = 16'h4000 | {14'd0, a};
    sys_rd  = 1'b1;
    @(negedge clk);
    sys_rd = 1'b0;
    v      = sys_data_out;
    rd_oe  = sys_data_oe;
    if (a == 2'd1 && m_q.size() != 0) void'(m_q.pop_front());
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] v);
    @(negedge clk);
    sys_adr     = 16'h4000 | {14'd0, a};
    sys_data_in = v;
    sys_wr      = 1'b1;
    @(negedge clk);
    sys_wr = 1'b0;
    if (a == 2'd2) begin
      m_irq_en = v[0];
      if (v[1]) begin m_q.delete(); m_e0 = 0; m_f0 = 0; end
      if (v[2]) begin m_ferr = 0; m_ovf = 0; end
    end
  endtask

  task automatic ps2_bit(input logic b);
    dev_data = b;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit b);
    logic par;
    par = (~^code) ^ b;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    repeat (5) @(negedge clk);
    m_frame(code, b);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{8'h1C, 1'b0, 8'h80, 1'b0, 8'h1C, 8'h00};
    vt[1] = '{8'hE0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00};
    vt[2] = '{8'hF0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00};
    vt[3] = '{8'h75, 1'b0, 8'hB0, 1'b0, 8'h75, 8'h00};
    vt[4] = '{8'h1C, 1'b1, 8'h40, 1'b0, 8'h00, 8'h40};
    m_reset();

    repeat (4) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    check("reset_dout", sys_data_out, 8'h00);
    check("reset_doe", sys_data_oe, 1'b0);
    check("reset_irq", sys_irq, 1'b1);
    check("reset_clk_oe", ps2_clk_oe, 1'b0);
    check("reset_data_oe", ps2_data_oe, 1'b0);
    bus_read(2'd0, d);
    check("reset_status", d, 8'h00);
    check("rd_oe_high", rd_oe, 1'b1);
    @(negedge clk);
    check("rd_oe_one_cycle", sys_data_oe, 1'b0);

    sys_adr = 16'h8000;
    sys_rd  = 1'b1;
    @(negedge clk);
    sys_rd = 1'b0;
    check("unselected_oe", sys_data_oe, 1'b0);

    for (int i = 0; i < 5; i++) begin
      send_frame(vt[i].code, vt[i].bad);
      bus_read(2'd0, d);
      check($sformatf("vec%0d_status", i), d, vt[i].st);
      check($sformatf("vec%0d_irq", i), sys_irq, vt[i].irq);
      bus_read(2'd1, d);
      check($sformatf("vec%0d_data", i), d, vt[i].rd);
      bus_read(2'd0, d);
      check($sformatf("vec%0d_status2", i), d, vt[i].st2);
    end

    bus_write(2'd2, 8'h05);
    bus_read(2'd0, d);
    check("clear_status", d, 8'h00);
    check("clear_irq", sys_irq, 1'b1);

    send_frame(8'h2A, 1'b0);
    bus_write(2'd2, 8'h00);
    check("masked_irq", sys_irq, 1'b1);
    bus_write(2'd2, 8'h01);
    check("unmasked_irq", sys_irq, 1'b0);
    bus_read(2'd1, d);
    check("masked_data", d, 8'h2A);

    send_frame(8'h11, 1'b0);
    send_frame(8'h12, 1'b0);
    send_frame(8'hE0, 1'b0);
    bus_write(2'd2, 8'h03);
    bus_read(2'd0, d);
    check("flush_status", d, 8'h00);
    send_frame(8'h13, 1'b0);
    bus_read(2'd0, d);
    check("flush_pend_gone", d, 8'h80);
    bus_read(2'd1, d);
    check("flush_next_data", d, 8'h13);

    for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b0);
    bus_read(2'd0, d);
    check("ovf_status", d, 8'h89);
    for (int i = 1; i <= DEPTH; i++) begin
      bus_read(2'd1, d);
      check($sformatf("ovf_data%0d", i), d, 8'(i));
    end
    bus_read(2'd0, d);
    check("ovf_sticky", d, 8'h08);
    bus_write(2'd2, 8'h05);

    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    dev_data = 1'b1;
    repeat (100) @(negedge clk);
    bus_read(2'd0, d);
    check("tmo_not_yet", d, 8'h00);
    repeat (250) @(negedge clk);
    m_ferr = 1;
    bus_read(2'd0, d);
    check("tmo_ferr", d, 8'h40);
    bus_write(2'd2, 8'h05);
    send_frame(8'h29, 1'b0);
    bus_read(2'd0, d);
    check("tmo_next_status", d, 8'h80);
    bus_read(2'd1, d);
    check("tmo_next_data", d, 8'h29);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      d = 8'hE0;
      else if (r == 1) d = 8'hF0;
      else             d = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 7) == 0);
      send_frame(d, bad);
      bus_read(2'd0, d);
      check($sformatf("rnd%0d_status", i), d, m_status());
      check($sformatf("rnd%0d_irq", i), sys_irq, m_irq());
      if ($urandom_range(0, 1) == 1) begin
        exp_d = (m_q.size() != 0) ? m_q[0][7:0] : 8'h00;
        bus_read(2'd1, d);
        check($sformatf("rnd%0d_data", i), d, exp_d);
      end
      if ($urandom_range(0, 7) == 0) bus_write(2'd2, 8'h05);
    end
    bus_write(2'd2, 8'h07);

`ifdef PS2_TX_EN
    bus_write(2'd3, 8'hFF);
    bus_read(2'd0, d);
    check("tx_busy_start", d, 8'h04);
    n = 0;
    while (clk_pin && n < 200) begin @(negedge clk); n++; end
    check("tx_inhibit_seen", clk_pin, 1'b0);
    n = 0;
    while (!clk_pin && n < INH + 200) begin @(negedge clk); n++; end
    check("tx_clk_released", clk_pin, 1'b1);
    check("tx_start_bit", data_pin, 1'b0);
    for (int e = 1; e <= 11; e++) begin
      if (e == 11) dev_data = 1'b0;
      bus_read(2'd0, d);
      check($sformatf("tx_busy_e%0d", e), d, 8'h04);
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (e <= 10) txbits[e-1] = data_pin;
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
    repeat (20) @(negedge clk);
    check("tx_data_bits", txbits[7:0], 8'hFF);
    check("tx_parity", txbits[8], 1'b1);
    check("tx_stop", txbits[9], 1'b1);
    bus_read(2'd0, d);
    check("tx_done_status", d, 8'h00);
    check("tx_done_irq", sys_irq, 1'b1);
`else
    bus_write(2'd3, 8'h55);
    repeat (INH + 20) @(negedge clk);
    bus_read(2'd0, d);
    check("tx_ignored_status", d, 8'h00);
    check("tx_ignored_clk_oe", ps2_clk_oe, 1'b0);
    check("tx_ignored_data_oe", ps2_data_oe, 1'b0);
`endif

    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    dev_data = 1'b1;
    n_reset  = 1'b0;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    m_reset();
    repeat (TMO + 100) @(negedge clk);
    bus_read(2'd0, d);
    check("midreset_status", d, 8'h00);
    check("midreset_irq", sys_irq, 1'b1);
    send_frame(8'h3A, 1'b0);
    bus_read(2'd1, d);
    check("midreset_next", d, 8'h3A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
